mem_wb_unit: RTL and testbench

//  Consumer of the EX-stage (alu_unit) result bundle. Runs the MEM and WB phases of the multi-cycle core.

---
 rtl/mem_wb_unit_pkg.sv | 16 +
 rtl/mem_wb_unit.sv | 124 ++++++++++++
 tb/tb_mem_wb_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_wb_unit_pkg.sv
// Shared phase codes for the multi-cycle core and the MEM/WB controller state encoding.
package mem_wb_unit_pkg;

  localparam logic [2:0] PH_IF  = 3'd0;
  localparam logic [2:0] PH_ID  = 3'd1;
  localparam logic [2:0] PH_EX  = 3'd2;
  localparam logic [2:0] PH_MEM = 3'd3;
  localparam logic [2:0] PH_WB  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mem_wb_unit.sv
// MEM and WB phases: optional data-memory load over req/ack, then register writeback,
// PC commit and a one-cycle done pulse. Tracks retired/skipped counts and a sticky timeout flag.
module mem_wb_unit
  import mem_wb_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             valid,
  input  logic             write,
  input  logic             data_en,
  input  logic [3:0]       data_addr,
  input  logic [4:0]       reg_addr,
  input  logic [7:0]       data_out,
  input  logic [7:0]       new_pc,
  input  logic [4:0]       rd_addr,
  output logic             mem_req,
  output logic [3:0]       mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic             pc_we,
  output logic [7:0]       pc_out,
  output logic             done,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] skipped_cnt
);

  wb_state_e st, nxt;

  logic       valid_q, write_q, load_q, fail_q;
  logic [3:0] addr_q;
  logic [4:0] dest_q;
  logic [7:0] dout_q, pc_q, rdata_q;
  logic [7:0] wait_cnt;

  logic start, load_in, timeout, enter_wb, valid_now;

  assign start     = (st == S_IDLE) && (state == PH_MEM);
  assign load_in   = valid && data_en;
  assign timeout   = (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign enter_wb  = (nxt == S_WB) && (st != S_WB);
  // A non-load goes straight from IDLE to WB, before the latch holds the new valid bit.
  assign valid_now = (st == S_IDLE) ? valid : valid_q;

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:  if (start) nxt = load_in ? S_REQ : S_WB;
      S_REQ:   if (mem_ack || timeout) nxt = S_WB;
      S_WB:    nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      load_q   <= 1'b0;
      fail_q   <= 1'b0;
      addr_q   <= '0;
      dest_q   <= '0;
      dout_q   <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (start) begin
        valid_q  <= valid;
        write_q  <= write;
        load_q   <= load_in;
        fail_q   <= 1'b0;
        addr_q   <= data_addr;
        dest_q   <= (reg_addr != 5'd0) ? reg_addr : rd_addr;
        dout_q   <= data_out;
        pc_q     <= new_pc;
        wait_cnt <= '0;
      end
      if (st == S_REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
        // An ack on the timeout edge wins over the timeout.
        if (mem_ack) begin
          rdata_q <= mem_rdata;
        end else if (timeout) begin
          fail_q  <= 1'b1;
          mem_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      skipped_cnt <= '0;
    end else if (enter_wb) begin
      if (valid_now) retired_cnt <= retired_cnt + 1'b1;
      else           skipped_cnt <= skipped_cnt + 1'b1;
    end
  end

  assign mem_req  = (st == S_REQ);
  assign mem_addr = addr_q;
  assign rf_we    = (st == S_WB) && valid_q && write_q && (dest_q != 5'd0) && !fail_q;
  assign rf_waddr = dest_q;
  assign rf_wdata = load_q ? rdata_q : dout_q;
  assign pc_we    = (st == S_WB);
  assign done     = (st == S_WB);
  assign pc_out   = pc_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed plus random instruction sequences against a transaction-level model of MEM/WB.
module tb_mem_wb_unit;
  import mem_wb_unit_pkg::*;

  localparam int T     = 16;
  localparam int CNT_W = 16;
  localparam int MAXC  = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       state;
  logic             valid, write, data_en;
  logic [3:0]       data_addr;
  logic [4:0]       reg_addr, rd_addr;
  logic [7:0]       data_out, new_pc;
  logic             mem_req, mem_ack;
  logic [3:0]       mem_addr;
  logic [7:0]       mem_rdata;
  logic             rf_we, pc_we, done, mem_err;
  logic [4:0]       rf_waddr;
  logic [7:0]       rf_wdata, pc_out;
  logic [CNT_W-1:0] retired_cnt, skipped_cnt;

  int total = 0;
  int bad   = 0;

  logic [CNT_W-1:0] ret_m = '0, skip_m = '0;
  logic             err_m = 1'b0;

  always #5 clk = ~clk;

  mem_wb_unit #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .state(state), .valid(valid), .write(write),
    .data_en(data_en), .data_addr(data_addr), .reg_addr(reg_addr),
    .data_out(data_out), .new_pc(new_pc), .rd_addr(rd_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_we(pc_we),
    .pc_out(pc_out), .done(done), .mem_err(mem_err),
    .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack_at: REQ cycle (1-based) in which mem_ack is driven; above T means never.
  task automatic run(input logic v, input logic w, input logic de, input logic [3:0] da,
                     input logic [4:0] ra, input logic [7:0] dout, input logic [7:0] npc,
                     input logic [4:0] rd, input int ack_at, input logic [7:0] rdat,
                     input bit pulse);
    int  reqs = 0;
    int  cycles = 0;
    bit  seen = 0;
    bit  is_load;
    bit  ok;
    int  exp_reqs;
    logic [4:0] dest;
    is_load  = v && de;
    ok       = !is_load || (ack_at <= T);
    exp_reqs = !is_load ? 0 : ((ack_at <= T) ? ack_at : T);
    dest     = (ra != 5'd0) ? ra : rd;

    @(negedge clk);
    valid = v; write = w; data_en = de; data_addr = da; reg_addr = ra;
    data_out = dout; new_pc = npc; rd_addr = rd; state = PH_MEM; mem_ack = 1'b0;
    @(negedge clk);
    state = PH_IF;
    // Scramble the EX bundle: the block must work from its own latched copy.
    valid = 1'($urandom); write = 1'($urandom); data_en = 1'($urandom);
    data_addr = 4'($urandom); reg_addr = 5'($urandom); data_out = 8'($urandom);
    new_pc = 8'($urandom); rd_addr = 5'($urandom);
    while (!seen && cycles < MAXC) begin
      if (done) begin
        seen = 1;
      end else begin
        if (mem_req) begin
          reqs++;
          chk("mem_addr", 32'(mem_addr), 32'(da));
          mem_ack   = (reqs == ack_at);
          mem_rdata = mem_ack ? rdat : 8'($urandom);
          state     = pulse ? PH_MEM : PH_IF;
        end else begin
          mem_ack = 1'b0;
          state   = PH_IF;
        end
        cycles++;
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    state   = PH_IF;

    chk("done_seen", 32'(seen), 32'd1);
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("latency", 32'(cycles), 32'(exp_reqs));
    if (v) ret_m++; else skip_m++;
    if (!ok) err_m = 1'b1;
    chk("rf_we", 32'(rf_we), 32'(v && w && (dest != 5'd0) && ok));
    chk("rf_waddr", 32'(rf_waddr), 32'(dest));
    if (ok) chk("rf_wdata", 32'(rf_wdata), 32'(is_load ? rdat : dout));
    chk("pc_we", 32'(pc_we), 32'd1);
    chk("pc_out", 32'(pc_out), 32'(npc));
    chk("retired_cnt", 32'(retired_cnt), 32'(ret_m));
    chk("skipped_cnt", 32'(skipped_cnt), 32'(skip_m));
    chk("mem_err", 32'(mem_err), 32'(err_m));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("pc_we_off", 32'(pc_we), 32'd0);
    chk("req_idle", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; state = PH_IF; valid = 0; write = 0; data_en = 0; data_addr = 0;
    reg_addr = 0; data_out = 0; new_pc = 0; rd_addr = 0; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_retired", 32'(retired_cnt), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;

    run(1, 1, 0, 4'd0, 5'd0,  8'h2A, 8'h11, 5'd5, 0, 8'h00, 0);   // ADDU
    run(1, 1, 1, 4'd3, 5'd0,  8'h00, 8'h12, 5'd9, 4, 8'h7E, 0);   // LW ack in 4th cycle
    run(1, 1, 1, 4'd6, 5'd0,  8'h00, 8'h13, 5'd7, 99, 8'h55, 0);  // LW timeout
    run(1, 1, 0, 4'd0, 5'd31, 8'h15, 8'h40, 5'd3, 0, 8'h00, 0);   // JAL
    run(0, 1, 1, 4'd2, 5'd0,  8'h33, 8'h41, 5'd4, 1, 8'h44, 0);   // invalid
    run(1, 1, 0, 4'd0, 5'd0,  8'h66, 8'h42, 5'd0, 0, 8'h00, 0);   // write to $0
    run(1, 1, 1, 4'd9, 5'd0,  8'h00, 8'h43, 5'd2, 5, 8'hA5, 1);   // MEM pulses during REQ
    run(1, 1, 1, 4'd1, 5'd0,  8'h00, 8'h44, 5'd8, T, 8'hC3, 0);   // ack on timeout edge
    run(1, 1, 1, 4'd4, 5'd0,  8'h00, 8'h45, 5'd0, 2, 8'h99, 0);   // load into $0

    // Reset in the middle of a load.
    @(negedge clk);
    valid = 1; write = 1; data_en = 1; data_addr = 4'd5; reg_addr = 0; rd_addr = 5'd6;
    new_pc = 8'h50; state = PH_MEM;
    @(negedge clk);
    state = PH_IF;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_req_drop", 32'(mem_req), 32'd0);
    chk("rst_no_done", 32'(done), 32'd0);
    chk("rst_cnt_ret", 32'(retired_cnt), 32'd0);
    chk("rst_cnt_skip", 32'(skipped_cnt), 32'd0);
    chk("rst_err_clr", 32'(mem_err), 32'd0);
    @(negedge clk);
    chk("rst_hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    ret_m = '0; skip_m = '0; err_m = 1'b0;
    run(1, 1, 0, 4'd0, 5'd0, 8'h77, 8'h51, 5'd10, 0, 8'h00, 0);

    for (int i = 0; i < 30; i++) begin
      run(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
          (($urandom_range(0, 3) == 0) ? 5'd31 : 5'd0), 8'($urandom), 8'($urandom),
          5'($urandom), int'($urandom_range(1, T + 3)), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
